uart_tx: RTL

- Byte-oriented 8N1 UART transmitter that drives usb_tx on the Cu board.
- It is the send half of the USB-serial link, pairing with the receive path on usb_rx.
- Upstream logic hands it bytes over a valid/ready handshake.
- A one-entry holding register lets the next byte be queued while the current frame shifts out, giving back-to-back frames with no idle gap.
- A block input provides flow control: it holds off new frames without corrupting a frame in flight.

---
 rtl/uart_tx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register for gap-free back-to-back frames.
// The block input defers new frames only at frame-start decision points.
module uart_tx #(
  parameter int CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tx,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       ready,
  input  logic       block,
  output logic       busy
);

  localparam int            CW       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CTR_LAST = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          accept_s;
  logic          bit_done_s;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    accept_s    = new_data & ~hold_full_q;
    bit_done_s  = (ctr_q == CTR_LAST);

    if (state_q == IDLE) begin
      ctr_d = '0;
    end else if (bit_done_s) begin
      ctr_d = '0;
    end else begin
      ctr_d = ctr_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        idx_d = 3'd0;
        if (hold_full_q && !block) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = START;
        end else if (accept_s && !block) begin
          shift_d = data;
          state_d = START;
        end else if (accept_s) begin
          hold_d      = data;
          hold_full_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_done_s && (idx_q == 3'd7)) begin
          state_d = STOP;
        end else if (bit_done_s) begin
          idx_d = idx_q + 3'd1;
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (bit_done_s && hold_full_q && !block) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = START;
        end else if (bit_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A transfer out of the holding register needs it full, so it never coincides with this accept
    if ((state_q != IDLE) && accept_s) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_d;
    end

    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    ready_d = ~hold_full_d;
    busy_d  = (state_d != IDLE) | hold_full_d;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule
